data_mem_mmio: RTL
==================

# data_mem_mmio

Data-memory stage for the single-cycle core: consumes the datapath's ALU result as a byte address, the store data and the control unit's MemWrite. Returns load data combinationally on the datapath's read-data input within the same cycle. Holds a word-addressed RAM plus a small memory-mapped timer/cycle-counter peripheral, giving programs a time base and an interrupt-style flag.

## Interface
Parameters:
- DEPTH_WORDS, 64, RAM size in 32-bit words (power of two, 4..1024)
- MMIO_BASE, 32'hFFFF_0000, byte base address of the peripheral register window (64-byte aligned)

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- WE  input  1  MemWrite from control unit; store occurs at next rising edge
- A  input  32  byte address (datapath ALU result)
- WD  input  32  store data (datapath register-file second read port)
- RD  output  32  load data, combinational from A and current state
- misaligned  output  1  high while A[1:0] != 0, combinational
- timer_irq  output  1  expired & irq_en, combinational from registers

## Operation
- Decode: RAM hit when A < DEPTH_WORDS*4, index A[log2(DEPTH_WORDS)+1:2]. MMIO hit when A[31:6] == MMIO_BASE[31:6], register offset A[5:2]. Anything else is unmapped.
- Misaligned access: RD returns the word at {A[31:2],2'b00}; stores with misaligned=1 are dropped entirely, with no state change.
- Unmapped: RD = 0; stores ignored.
- MMIO registers (word offset):
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x04 LOAD: writing sets LOAD and COUNT to WD.
  - 0x08 COUNT: read-only; writes ignored.
  - 0x0C STATUS: bit0 expired; writing 1 to bit0 clears it, writing 0 has no effect.
  - 0x10 CYCLES: free-running counter; a write makes its next value WD.
  - Offsets 0x14..0x3C read 0; writes ignored.
- Timer, per cycle, evaluated in priority order:
  1. A LOAD write loads COUNT.
  2. Otherwise, if enable and COUNT != 0, COUNT decrements by 1.
  3. Otherwise, if enable and COUNT == 0: expired is set. With auto_reload=1, COUNT <= LOAD. With auto_reload=0, enable is cleared and COUNT stays 0.
- STATUS clear and hardware set of expired in the same cycle: set wins (expired = 1).
- CTRL write in the same cycle as a hardware enable-clear: the CTRL write wins.
- CYCLES increments by 1 every cycle, wrapping 32'hFFFF_FFFF -> 0. A write overrides the increment for that cycle.
- All arithmetic is unsigned 32-bit modulo 2^32.

## Timing
- Reset (rst low, asynchronous): all RAM words = 0, CTRL = 0, LOAD = 0, COUNT = 0, STATUS = 0, CYCLES = 0. Consequently RD = 0 for all addresses, timer_irq = 0, and misaligned follows A only.
- Loads: zero latency. RD is valid in the same cycle A is presented, as the single-cycle datapath requires.
- Stores: visible to reads starting the cycle after the rising edge on which WE=1 is sampled. Same-cycle read-after-write returns the old value.
- After reset release, CYCLES reads 1 on the cycle after the first rising edge.
- Timer with LOAD=N, enable set at edge k: COUNT reaches 0 at edge k+N and expired sets at edge k+N+1. Period with auto-reload is N+1 cycles.
- Reset asserted mid-countdown aborts immediately; no expired pulse is generated.

## Test plan
- Reset, then read addresses 0x0, 0xFC and MMIO_BASE+0x08 -> RD = 0 for each, timer_irq = 0.
- Store 0xDEADBEEF to 0x10, read 0x10 in the same cycle -> old value 0. Read 0x10 the next cycle -> 0xDEADBEEF. Store to 0x13 (misaligned) -> misaligned=1 and 0x10 is unchanged.
- Store 0x1234 to 0x200 (unmapped) -> read 0x200 returns 0, and RAM words 0x0..0xFC are unchanged.
- Write LOAD=3, then CTRL=0b101 -> COUNT reads 3,2,1,0 on successive cycles, expired and timer_irq go high one cycle later, and CTRL.enable clears. Repeat with CTRL=0b111 -> expired sets every 4 cycles.
- With expired=1, write STATUS=1 in the exact cycle the hardware sets expired again -> expired stays 1. Write STATUS=1 in a quiet cycle -> expired becomes 0 and timer_irq becomes 0.
- Write CYCLES=32'hFFFF_FFFE -> reads FFFF_FFFE, FFFF_FFFF, 0 on the following cycles. Pulse rst low for half a cycle mid-count -> CYCLES, COUNT and CTRL read 0.

Source files
------------

// File: rtl/data_mem_mmio.sv
// Data-memory stage for the single-cycle core: word RAM plus a memory-mapped
// timer/cycle-counter peripheral. Loads are combinational and stores commit
// on the rising edge. All state is cleared by an asynchronous active-low reset.
module data_mem_mmio #(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WE,
  input  logic [31:0] A,
  input  logic [31:0] WD,
  output logic [31:0] RD,
  output logic        misaligned,
  output logic        timer_irq
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  // Peripheral register word offsets (A[5:2])
  localparam logic [3:0] OFF_CTRL   = 4'd0;
  localparam logic [3:0] OFF_LOAD   = 4'd1;
  localparam logic [3:0] OFF_COUNT  = 4'd2;
  localparam logic [3:0] OFF_STATUS = 4'd3;
  localparam logic [3:0] OFF_CYCLES = 4'd4;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic        en_q, en_d;
  logic        auto_reload_q, auto_reload_d;
  logic        irq_en_q, irq_en_d;
  logic        expired_q, expired_d;
  logic [31:0] load_q, load_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cycles_q, cycles_d;

  logic          ram_hit, mmio_hit;
  logic [AW-1:0] ram_idx;
  logic [3:0]    reg_off;
  logic          store_ok, ram_we, mmio_we;
  logic          ctrl_wr, load_wr, status_wr, cycles_wr;
  logic          hw_fire;

  // Address decode; the low two address bits never select a different word.
  assign misaligned = |A[1:0];
  assign ram_hit    = (A < RAM_BYTES);
  assign mmio_hit   = (A[31:6] == MMIO_BASE[31:6]);
  assign ram_idx    = A[AW+1:2];
  assign reg_off    = A[5:2];

  // Misaligned stores are dropped entirely; unmapped stores fall through.
  assign store_ok   = WE & ~misaligned;
  assign ram_we     = store_ok & ram_hit;
  assign mmio_we    = store_ok & ~ram_hit & mmio_hit;
  assign ctrl_wr    = mmio_we & (reg_off == OFF_CTRL);
  assign load_wr    = mmio_we & (reg_off == OFF_LOAD);
  assign status_wr  = mmio_we & (reg_off == OFF_STATUS);
  assign cycles_wr  = mmio_we & (reg_off == OFF_CYCLES);

  assign timer_irq  = expired_q & irq_en_q;

  // One storage word per generate slot, cleared by reset, written on an index match
  for (genvar gi = 0; gi < int'(DEPTH_WORDS); gi++) begin : g_ram
    localparam logic [AW-1:0] IDX = AW'(gi);
    // Commit a store to this word on the clock edge
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        mem_q[gi] <= '0;
      end else if (ram_we && (ram_idx == IDX)) begin
        mem_q[gi] <= WD;
      end
    end
  end

  // Combinational load path: RAM word, peripheral register, or zero
  always_comb begin
    RD = '0;
    if (ram_hit) begin
      RD = mem_q[ram_idx];
    end else if (mmio_hit) begin
      case (reg_off)
        OFF_CTRL:   RD = {29'd0, irq_en_q, auto_reload_q, en_q};
        OFF_LOAD:   RD = load_q;
        OFF_COUNT:  RD = count_q;
        OFF_STATUS: RD = {31'd0, expired_q};
        OFF_CYCLES: RD = cycles_q;
        default:    RD = '0;
      endcase
    end
  end

  // Timer and cycle-counter next state; later assignments carry the higher priority
  always_comb begin
    en_d          = en_q;
    auto_reload_d = auto_reload_q;
    irq_en_d      = irq_en_q;
    expired_d     = expired_q;
    load_d        = load_q;
    count_d       = count_q;
    hw_fire       = 1'b0;

    if (load_wr) begin
      load_d  = WD;
      count_d = WD;
    end else if (en_q) begin
      if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end else begin
        hw_fire = 1'b1;
        if (auto_reload_q) count_d = load_q;
        else               en_d    = 1'b0;
      end
    end

    // Software clear loses to a simultaneous hardware expiry
    if (status_wr && WD[0]) expired_d = 1'b0;
    if (hw_fire)            expired_d = 1'b1;

    // A CTRL write overrides the one-shot enable clear
    if (ctrl_wr) begin
      en_d          = WD[0];
      auto_reload_d = WD[1];
      irq_en_d      = WD[2];
    end

    cycles_d = cycles_wr ? WD : (cycles_q + 32'd1);
  end

  // Peripheral register state update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_q          <= 1'b0;
      auto_reload_q <= 1'b0;
      irq_en_q      <= 1'b0;
      expired_q     <= 1'b0;
      load_q        <= '0;
      count_q       <= '0;
      cycles_q      <= '0;
    end else begin
      en_q          <= en_d;
      auto_reload_q <= auto_reload_d;
      irq_en_q      <= irq_en_d;
      expired_q     <= expired_d;
      load_q        <= load_d;
      count_q       <= count_d;
      cycles_q      <= cycles_d;
    end
  end

endmodule
